// File: rtl/raster_pkg.sv
// Shared definitions for the rasterizer -> pixel FIFO -> framebuffer path:
// pixel word field layout, flush marker, default geometry and FSM states.
package raster_pkg;

  localparam int Y_MSB = 88;
  localparam int Y_LSB = 80;
  localparam int X_MSB = 73;
  localparam int X_LSB = 64;
  localparam int R_MSB = 55;
  localparam int R_LSB = 50;
  localparam int G_MSB = 47;
  localparam int G_LSB = 42;
  localparam int B_MSB = 39;
  localparam int B_LSB = 34;

  localparam int COORD_X_W = X_MSB - X_LSB + 1;
  localparam int COORD_Y_W = Y_MSB - Y_LSB + 1;
  localparam int COLOUR_W  = 18;

  localparam logic [95:0] FLUSH_MARKER = {96{1'b1}};

  localparam int DEF_H_RES  = 640;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_ADDR_W = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_FLUSH
  } state_t;

  function automatic logic [COLOUR_W-1:0] pack_rgb(input logic [95:0] w);
    return {w[R_MSB:R_LSB], w[G_MSB:G_LSB], w[B_MSB:B_LSB]};
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational pixel coordinate -> linear framebuffer address, plus an
// out-of-range flag for coordinates outside the active area.
module fb_addr_gen
  import raster_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [COORD_X_W-1:0] x,
  input  logic [COORD_Y_W-1:0] y,
  output logic [ADDR_W-1:0]    addr,
  output logic                 out_of_range
);

  localparam logic [COORD_X_W:0] H_LIM = (COORD_X_W+1)'(H_RES);
  localparam logic [COORD_Y_W:0] V_LIM = (COORD_Y_W+1)'(V_RES);

  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;

  assign x_ext = ADDR_W'(x);
  assign y_ext = ADDR_W'(y);

  // 640 = 512 + 128, so the default geometry needs only two shifted adds.
  generate
    if (H_RES == 640) begin : g_shift_add
      assign addr = (y_ext << 9) + (y_ext << 7) + x_ext;
    end else begin : g_const_mul
      assign addr = y_ext * ADDR_W'(H_RES) + x_ext;
    end
  endgenerate

  assign out_of_range = ({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM);

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel FIFO consumer: decodes each pixel word into one req/ack framebuffer
// write and treats the all-ones word as end-of-frame. FB_DOUBLE_BUFFER_EN adds
// back-buffer toggling on each flush and the front_buf output.
//
// Handshakes: the FIFO read is a strobe (rd_en) with rd_data valid the next
// cycle; the memory write holds mem_req, mem_addr and mem_data stable until
// the cycle in which mem_ack=1 is seen with mem_req=1, which completes it.
module fb_pixel_writer
  import raster_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                empty,
  output logic                rd_en,
  input  logic [95:0]         rd_data,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic [ADDR_W:0]     mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                frame_done,
  output logic                busy,
  output logic [19:0]         pixel_count,
  output logic [15:0]         drop_count,
  output state_t              dbg_state
`ifdef FB_DOUBLE_BUFFER_EN
  ,
  output logic                front_buf
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] lin_addr;
  logic              out_of_range;
  logic              is_flush;
  logic              buf_sel;

  fb_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .x            (rd_data[X_MSB:X_LSB]),
    .y            (rd_data[Y_MSB:Y_LSB]),
    .addr         (lin_addr),
    .out_of_range (out_of_range)
  );

  assign is_flush  = (rd_data == FLUSH_MARKER);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!empty) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (is_flush)          state_nxt = ST_FLUSH;
        else if (out_of_range) state_nxt = ST_IDLE;
        else                   state_nxt = ST_WRITE;
      end
      ST_WRITE: if (mem_ack) state_nxt = ST_IDLE;
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request and pulse outputs are pure state decodes, so an asynchronous
  // reset drops mem_req immediately.
  always_comb begin
    rd_en      = (state == ST_IDLE) && !empty;
    mem_req    = (state == ST_WRITE);
    frame_done = (state == ST_FLUSH);
    busy       = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      mem_data <= '0;
    end else if (state == ST_FETCH && !is_flush && !out_of_range) begin
      mem_addr <= {buf_sel, lin_addr};
      mem_data <= pack_rgb(rd_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_count <= '0;
    end else if (state == ST_FLUSH) begin
      pixel_count <= '0;
    end else if (state == ST_WRITE && mem_ack) begin
      pixel_count <= pixel_count + 20'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (state == ST_FETCH && !is_flush && out_of_range &&
                 drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  // front_buf follows the buffer just completed; buf_sel moves to the other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_sel   <= 1'b0;
      front_buf <= 1'b0;
    end else if (state == ST_FLUSH) begin
      buf_sel   <= ~buf_sel;
      front_buf <= buf_sel;
    end
  end
`else
  assign buf_sel = 1'b0;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: FIFO and memory models driven from one directed
// sequence, with a queue-based reference of expected writes and frame ends.
module tb_fb_pixel_writer;
  import raster_pkg::*;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          empty;
  logic          rd_en;
  logic [95:0]   rd_data;
  logic          mem_req;
  logic          mem_ack;
  logic [AW:0]   mem_addr;
  logic [17:0]   mem_data;
  logic          frame_done;
  logic          busy;
  logic [19:0]   pixel_count;
  logic [15:0]   drop_count;
  state_t        dbg_state;
`ifdef FB_DOUBLE_BUFFER_EN
  logic          front_buf;
`endif

  fb_pixel_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .empty       (empty),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .frame_done  (frame_done),
    .busy        (busy),
    .pixel_count (pixel_count),
    .drop_count  (drop_count),
    .dbg_state   (dbg_state)
`ifdef FB_DOUBLE_BUFFER_EN
    ,
    .front_buf   (front_buf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [95:0] fifo_q[$];
  logic [37:0] exp_q[$];
  int          fd_q[$];
  int          wr_times[$];
  int          model_pix  = 0;
  int          model_drop = 0;
  bit          model_buf  = 1'b0;
  int          fd_seen    = 0;
  bit          hold_valid = 1'b0;
  logic [AW:0] held_addr;
  logic [17:0] held_data;
  logic [AW:0] last_addr;
  logic [17:0] last_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [95:0] mk(input int x, input int y, input int r, input int g, input int b);
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    w[88:80] = 9'(y);
    w[73:64] = 10'(x);
    w[55:50] = 6'(r);
    w[47:42] = 6'(g);
    w[39:34] = 6'(b);
    return w;
  endfunction

  // Reference: what the consumed word must eventually cause.
  task automatic model_apply(input logic [95:0] w, input int c);
    int x, y;
    x = int'(w[73:64]);
    y = int'(w[88:80]);
    if (w == FLUSH_MARKER) begin
      fd_q.push_back(c + 2);
      model_pix = 0;
`ifdef FB_DOUBLE_BUFFER_EN
      model_buf = ~model_buf;
`endif
    end else if (x >= H || y >= V) begin
      if (model_drop < 65535) model_drop++;
    end else begin
      exp_q.push_back({model_buf, 19'(y * H + x), w[55:50], w[47:42], w[39:34]});
    end
  endtask

  task automatic cycle(input bit ack);
    logic [95:0] w;
    bit popped;
    logic [37:0] e;
    popped = 1'b0;
    @(negedge clk);
    mem_ack = ack;
    empty   = (fifo_q.size() == 0);
    #1;
    cyc++;
    check("rd_en_with_req", rd_en & mem_req, 1'b0);
    if (mem_req) begin
      if (hold_valid) begin
        check("hold_addr", mem_addr, held_addr);
        check("hold_data", mem_data, held_data);
      end
      if (mem_ack) begin
        if (exp_q.size() == 0) check("spurious_write", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e[37:18]);
          check("wr_data", mem_data, e[17:0]);
        end
        last_addr = mem_addr;
        last_data = mem_data;
        model_pix++;
        wr_times.push_back(cyc);
        hold_valid = 1'b0;
      end else begin
        hold_valid = 1'b1;
        held_addr  = mem_addr;
        held_data  = mem_data;
      end
    end else begin
      hold_valid = 1'b0;
    end
    if (frame_done) begin
      fd_seen++;
      if (fd_q.size() == 0) check("frame_done_unexpected", 1'b1, 1'b0);
      else check("frame_done_cycle", cyc, fd_q.pop_front());
    end
    if (rd_en) begin
      if (fifo_q.size() == 0) check("rd_en_when_empty", 1'b1, 1'b0);
      else begin
        w = fifo_q.pop_front();
        model_apply(w, cyc);
        popped = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (popped) rd_data = w;
  endtask

  task automatic drain(input bit random_ack);
    int n;
    n = 0;
    do begin
      cycle(random_ack ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end while ((fifo_q.size() != 0 || busy || exp_q.size() != 0 || fd_q.size() != 0) && n < 3000);
    if (n >= 3000) check("drain_timeout", 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, rd_en, 1'b0);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_data"}, mem_data, '0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pixel_count"}, pixel_count, '0);
    check({tag, "_drop_count"}, drop_count, '0);
`ifdef FB_DOUBLE_BUFFER_EN
    check({tag, "_front_buf"}, front_buf, 1'b0);
`endif
  endtask

  initial begin
    int base, n, sel, fd0;

    // Reset
    rst = 1'b1; empty = 1'b1; mem_ack = 1'b0; rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    cycle(1'b0);
    check("idle_not_busy", busy, 1'b0);

    // Single pixel with immediate ack
    fifo_q.push_back(mk(5, 2, 'h3F, 0, 'h15));
    drain(1'b0);
    check("t1_addr", last_addr, 20'd1285);
    check("t1_data", last_data, 18'h3F015);
    check("t1_pixel_count", pixel_count, 20'd1);

    // Ack withheld: request must hold and no further read may occur
    fifo_q.push_back(mk(639, 479, 1, 2, 3));
    fifo_q.push_back(mk(0, 0, 4, 5, 6));
    n = 0;
    while (!mem_req && n < 10) begin cycle(1'b0); n++; end
    check("stall_req_seen", mem_req, 1'b1);
    repeat (10) begin
      cycle(1'b0);
      check("stall_req_held", mem_req, 1'b1);
      check("stall_no_rd", rd_en, 1'b0);
    end
    drain(1'b0);
    check("stall_pixel_count", pixel_count, 20'(model_pix));

    // Out-of-range pixel is dropped, following word written normally
    fifo_q.push_back(mk(700, 10, 7, 7, 7));
    fifo_q.push_back(mk(3, 4, 8, 9, 10));
    drain(1'b0);
    check("drop_count_1", drop_count, 16'd1);
    check("drop_next_written", last_addr, 20'(4 * H + 3));
    check("drop_pixel_count", pixel_count, 20'(model_pix));

    // Three pixels then flush marker
    fd0 = fd_seen;
    for (int i = 0; i < 3; i++) fifo_q.push_back(mk(10 + i, 20, i, i, i));
    fifo_q.push_back(FLUSH_MARKER);
    drain(1'b0);
    check("flush_one_pulse", fd_seen - fd0, 1);
    check("flush_pixel_count", pixel_count, 20'd0);
    fifo_q.push_back(mk(1, 1, 1, 1, 1));
    drain(1'b0);
`ifdef FB_DOUBLE_BUFFER_EN
    check("flush_buf_bit", last_addr[AW], 1'b1);
    check("front_buf", front_buf, ~model_buf);
`else
    check("flush_buf_bit", last_addr[AW], 1'b0);
`endif
    check("post_flush_count", pixel_count, 20'd1);

    // Back-to-back full FIFO, ack tied high
    base = wr_times.size();
    for (int i = 0; i < 8; i++)
      fifo_q.push_back(mk($urandom_range(0, H - 1), $urandom_range(0, V - 1),
                          $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)));
    drain(1'b0);
    check("thru_writes", wr_times.size() - base, 8);
    for (int i = base + 1; i < wr_times.size(); i++)
      check("thru_gap", wr_times[i] - wr_times[i - 1], 3);

    // Randomised mix with random ack delays
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 5) fifo_q.push_back(FLUSH_MARKER);
      else if (sel < 15)
        fifo_q.push_back(mk($urandom_range(H, 1023), $urandom_range(0, 511), 1, 1, 1));
      else
        fifo_q.push_back(mk($urandom_range(0, H - 1), $urandom_range(0, V - 1),
                            $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63)));
    end
    drain(1'b1);
    check("rand_pixel_count", pixel_count, 20'(model_pix));
    check("rand_drop_count", drop_count, 16'(model_drop));

    // Reset during WRITE
    fifo_q.push_back(mk(100, 100, 9, 9, 9));
    n = 0;
    while (!mem_req && n < 10) begin cycle(1'b0); n++; end
    check("rst_req_seen", mem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    fd_q.delete();
    model_pix = 0; model_drop = 0; model_buf = 1'b0; hold_valid = 1'b0;
    #1;
    rst = 1'b0;
    cycle(1'b1);
    check("post_rst_idle", busy, 1'b0);
    fifo_q.push_back(mk(6, 7, 'h2A, 'h15, 'h3F));
    drain(1'b0);
    check("post_rst_addr", last_addr, 20'(7 * H + 6));
    check("post_rst_data", last_data, 18'h2A57F);
    check("post_rst_count", pixel_count, 20'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
